// File: rtl/extension_arbiter_pkg.sv
// extension_arbiter_pkg: extension mode codes and result-slot FSM encoding shared by the arbiter and its extender.
package extension_arbiter_pkg;

    typedef enum logic [1:0] {
        MODE_SIGN    = 2'b00,
        MODE_ZERO    = 2'b01,
        MODE_UPPER   = 2'b10,
        MODE_INVALID = 2'b11
    } ext_mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FULL = 1'b1
    } state_e;

endpackage

// File: rtl/Extensor_Signo.sv
// Extensor_Signo: combinational immediate extender (sign, zero, upper-shift; invalid mode gives all ones).
module Extensor_Signo
    import extension_arbiter_pkg::*;
#(
    parameter int I_NB = 16,
    parameter int O_NB = 32
) (
    input  logic [I_NB-1:0] i_imm,
    input  logic [1:0]      i_mode,
    output logic [O_NB-1:0] o_ext
);

    localparam int X_NB = O_NB - I_NB;

    always_comb begin
        o_ext = i_mode == MODE_SIGN  ? {{X_NB{i_imm[I_NB-1]}}, i_imm} :
                i_mode == MODE_ZERO  ? {{X_NB{1'b0}}, i_imm} :
                i_mode == MODE_UPPER ? {i_imm, {X_NB{1'b0}}} :
                                       {O_NB{1'b1}};
    end

endmodule

// File: rtl/extension_arbiter.sv
// extension_arbiter: two requesters share one extender behind a single-entry result register.
// Define EXT_ARB_RR_EN for round-robin grant; otherwise requester 0 has fixed priority.
module extension_arbiter
    import extension_arbiter_pkg::*;
#(
    parameter int I_NB = 16,
    parameter int O_NB = 32
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_req0_valid,
    input  logic [I_NB-1:0] i_req0_imm,
    input  logic [1:0]      i_req0_mode,
    output logic            o_req0_ready,
    input  logic            i_req1_valid,
    input  logic [I_NB-1:0] i_req1_imm,
    input  logic [1:0]      i_req1_mode,
    output logic            o_req1_ready,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [O_NB-1:0] o_result,
    output logic            o_tag,
    output logic            o_mode_err
);

    state_e          state, state_nx;
    logic            slot_free;
    logic            gnt1;
    logic            accept;
    logic [I_NB-1:0] sel_imm;
    logic [1:0]      sel_mode;
    logic [O_NB-1:0] ext;

`ifdef EXT_ARB_RR_EN
    // rr_ptr=1 means requester 1 wins a tie; it points away from whoever was served last.
    logic rr_ptr;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            rr_ptr <= 1'b0;
        else if (accept)
            rr_ptr <= ~gnt1;
    end
    assign gnt1 = i_req1_valid && (!i_req0_valid || rr_ptr);
`else
    assign gnt1 = i_req1_valid && !i_req0_valid;
`endif

    // Readies are gated by reset so they drop immediately, not at the next edge.
    assign slot_free    = i_reset_n && (state == S_IDLE || i_ready);
    assign o_req0_ready = slot_free && !gnt1;
    assign o_req1_ready = slot_free && gnt1;
    assign accept       = (i_req0_valid && o_req0_ready) || (i_req1_valid && o_req1_ready);
    assign sel_imm      = gnt1 ? i_req1_imm : i_req0_imm;
    assign sel_mode     = gnt1 ? i_req1_mode : i_req0_mode;
    assign o_valid      = state == S_FULL;

    Extensor_Signo #(
        .I_NB(I_NB),
        .O_NB(O_NB)
    ) u_ext (
        .i_imm (sel_imm),
        .i_mode(sel_mode),
        .o_ext (ext)
    );

    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = S_FULL;
        else if (state == S_FULL && i_ready)
            state_nx = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            o_result   <= '0;
            o_tag      <= 1'b0;
            o_mode_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                o_result   <= ext;
                o_tag      <= gnt1;
                o_mode_err <= sel_mode == MODE_INVALID;
            end
        end
    end

endmodule

// File: doc/extension_arbiter.md
EXTENSION_ARBITER -- requirements
Module: extension_arbiter

Interface
REQ-001 Parameter I_NB, default 16, immediate input width.
REQ-002 Parameter O_NB, default 32, extended result width; O_NB-I_NB is the extension width.
REQ-003 i_clk  input  1  single clock, all state updates on rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req0_valid / i_req0_imm / i_req0_mode  input  1 / I_NB / 2  requester 0 (decode stage): request, immediate, extension mode.
REQ-006 o_req0_ready  output  1  requester 0 accepted this cycle when valid&&ready.
REQ-007 i_req1_valid / i_req1_imm / i_req1_mode  input  1 / I_NB / 2  requester 1 (debug unit): same meaning.
REQ-008 o_req1_ready  output  1  requester 1 handshake ready.
REQ-009 o_valid  output  1  result register holds an unconsumed result.
REQ-010 i_ready  input  1  consumer accepts result when o_valid&&i_ready.
REQ-011 o_result / o_tag / o_mode_err  output  O_NB / 1 / 1  extended value, originating requester (0/1), mode-11 flag.

Function
REQ-012 Modes: 00 sign-extend, 01 zero-extend, 10 immediate shifted to upper bits with zero low bits, 11 invalid -> result all ones and o_mode_err=1.
REQ-013 One shared extender; at most one request accepted per cycle.
REQ-014 FSM states IDLE (result register empty) and FULL (o_valid=1).
REQ-015 Slot free when state IDLE, or FULL with i_ready=1 (same-cycle drain and refill allowed).
REQ-016 Ready asserted only to the granted requester and only when slot free; ready never depends on that requester's own valid other than through the grant.
REQ-017 Default grant: requester 0 fixed priority; requester 1 granted only when requester 0 is not valid.
REQ-018 Latency one cycle: request accepted at edge N -> o_valid, o_result, o_tag, o_mode_err valid after edge N.
REQ-019 While o_valid=1 and i_ready=0, all outputs held stable and both readies low.
REQ-020 FULL -> IDLE when i_ready=1 and no acceptance; FULL -> FULL on drain+refill; IDLE -> FULL on acceptance.
REQ-021 Simultaneous valid on both requesters: exactly one accepted; the other holds valid and is served later.
REQ-022 Requester inputs sampled only on acceptance; changes to non-accepted inputs have no effect.

Reset
REQ-023 Asserting i_reset_n low at any time, including mid-handshake, immediately forces IDLE, o_valid=0, o_result=0, o_tag=0, o_mode_err=0, both readies 0, round-robin pointer=0.
REQ-024 Any in-flight result at reset is discarded; first grant possible in the first cycle after reset release.

Configuration
REQ-025 Macro EXT_ARB_RR_EN: when defined, grant is round-robin; pointer toggles to the other requester after each acceptance; with both valid, the requester not last served wins.
REQ-026 Without EXT_ARB_RR_EN, fixed priority per REQ-017 and no pointer flop exists.

Structure
REQ-027 Shared package holds extension mode constants (SIGN=00, ZERO=01, UPPER=10, INVALID=11) and FSM state encoding.
REQ-028 One sub-module: the existing combinational extender Extensor_Signo, instantiated once, fed by the grant mux; mode 11 flag generated in this block.

Verification
REQ-029 Req0 valid imm=16'h8000 mode=00, i_ready=1 -> next cycle o_result=32'hFFFF8000, o_tag=0, o_mode_err=0.
REQ-030 Req1 only, imm=16'h8000 mode=10 -> o_result=32'h80000000, o_tag=1; mode=01 -> 32'h00008000.
REQ-031 Both valid continuously, i_ready=1: fixed build -> tags 0,0,0...; EXT_ARB_RR_EN build -> tags 0,1,0,1.
REQ-032 Result pending, i_ready=0 for 3 cycles -> outputs stable, both readies 0; then i_ready=1 with req0 valid -> drain and new accept in same cycle.
REQ-033 Mode=11 imm=16'h1234 -> o_result=32'hFFFFFFFF, o_mode_err=1.
REQ-034 i_reset_n low while o_valid=1 -> o_valid=0 without a clock edge; after release, req1 served first when req0 idle.
